// File: rtl/unet_pkg.sv
// Shared definitions for the segmentation-network decoder blocks:
// FSM state encodings and a counter-width helper.
package unet_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ROW_PASS   = 2'd1;
    localparam logic [1:0] ROW_REPEAT = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/row_line_buffer.sv
// One-row pixel store used to replay an input row. Single port, combinational
// read, storage deliberately left unreset.
module row_line_buffer #(
    parameter int DEPTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/upsample2x_block.sv
// Nearest-neighbour 2x upsampler: each input pixel is emitted twice on the
// fly, then the whole row is replayed from the line buffer.
module upsample2x_block
    import unet_pkg::*;
#(
    parameter int IMG_HEIGHT = 128,
    parameter int IMG_WIDTH  = 128,
    parameter int CHANNELS   = 64,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] feature_in,
    input  logic                  feature_valid,
    output logic                  feature_ready,
    output logic [DATA_WIDTH-1:0] feature_out,
    output logic                  feature_valid_out,
    output logic                  upsample_done
);

    localparam int COL_W = clog2_min1(IMG_WIDTH);
    localparam int ROW_W = clog2_min1(IMG_HEIGHT);
    localparam int CH_W  = clog2_min1(CHANNELS);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    logic [1:0]            state_q, state_d;
    logic                  dup_q, dup_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  vld_q, vld_d;
    logic                  done_q, done_d;

    logic                  buf_we;
    logic [DATA_WIDTH-1:0] buf_rdata;
    logic                  xfer;

    assign feature_ready = (state_q == ROW_PASS) && !dup_q;
    assign xfer          = feature_valid && feature_ready;

    row_line_buffer #(
        .DEPTH      (IMG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (COL_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (col_q),
        .wdata (feature_in),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        dup_d   = dup_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        buf_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROW_PASS;
                    dup_d   = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end

            ROW_PASS: begin
                if (!dup_q) begin
                    if (xfer) begin
                        buf_we = 1'b1;
                        out_d  = feature_in;
                        vld_d  = 1'b1;
                        dup_d  = 1'b1;
                    end
                end else begin
                    // out_q still holds the pixel, so the duplicate is a re-emit
                    vld_d = 1'b1;
                    dup_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ROW_REPEAT;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            ROW_REPEAT: begin
                out_d = buf_rdata;
                vld_d = 1'b1;
                dup_d = !dup_q;
                if (dup_q) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (ch_q == CH_LAST) begin
                                ch_d    = '0;
                                state_d = DONE;
                            end else begin
                                ch_d    = ch_q + CH_W'(1);
                                state_d = ROW_PASS;
                            end
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = ROW_PASS;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dup_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dup_q   <= dup_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign feature_out       = out_q;
    assign feature_valid_out = vld_q;
    assign upsample_done     = done_q;

endmodule

// File: tb/tb_upsample2x_block.sv
// Directed bench for upsample2x_block: a 2x4 single-plane instance and a
// 2x4 two-plane instance share the input stream, each with its own start.
module tb_upsample2x_block;

    localparam int W    = 4;
    localparam int MAXC = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] feature_in;
    logic        feature_valid;
    logic        ready_a, vld_a, done_a;
    logic        ready_b, vld_b, done_b;
    logic [15:0] out_a, out_b;

    always #5 clk = ~clk;

    upsample2x_block #(.IMG_HEIGHT(2), .IMG_WIDTH(4), .CHANNELS(1), .DATA_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .feature_in(feature_in),
        .feature_valid(feature_valid), .feature_ready(ready_a), .feature_out(out_a),
        .feature_valid_out(vld_a), .upsample_done(done_a)
    );

    upsample2x_block #(.IMG_HEIGHT(2), .IMG_WIDTH(4), .CHANNELS(2), .DATA_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .feature_in(feature_in),
        .feature_valid(feature_valid), .feature_ready(ready_b), .feature_out(out_b),
        .feature_valid_out(vld_b), .upsample_done(done_b)
    );

    bit          sel;
    logic        rdy, vld, dn;
    logic [15:0] dout;
    assign rdy  = sel ? ready_b : ready_a;
    assign vld  = sel ? vld_b   : vld_a;
    assign dn   = sel ? done_b  : done_a;
    assign dout = sel ? out_b   : out_a;

    int n_cmp = 0;
    int n_err = 0;

    int beats[$];
    int beat_cyc[$];
    int done_cnt, done_cyc, xfers, first_xfer_cyc;
    logic done_vld, idle_rdy;

    typedef struct {
        string name;
        bit    use_b;
        int    npix;
        int    bub;
        int    start_beat;
        int    exp_beats;
        int    s0i, s0v, s1i, s1v, s2i, s2v;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output beat k of a frame: 4*W beats per input row, row pair replays the row.
    function automatic int exp_beat(input int k);
        int r, m;
        r = k / (4 * W);
        m = (k % (4 * W)) % (2 * W);
        return r * W + m / 2 + 1;
    endfunction

    task automatic run_frame(input bit use_b, input int npix, input int bub_len,
                             input int start_beat, input int rst_after, output bit timed_out);
        int idx, bub_cnt;
        bit fin, started;
        sel = use_b;
        beats.delete();
        beat_cyc.delete();
        done_cnt = 0; done_cyc = -1; done_vld = 1'b0; xfers = 0; first_xfer_cyc = -1;
        idle_rdy = 1'b1; idx = 0; bub_cnt = 0; fin = 1'b0; started = 1'b0;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int cyc = 0; cyc < MAXC && !fin; cyc++) begin
            if (vld) begin
                beats.push_back(int'(dout));
                beat_cyc.push_back(cyc);
            end
            if (dn) begin
                done_cnt++;
                done_cyc = cyc;
                done_vld = vld;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                idle_rdy = rdy;
                fin = 1'b1;
            end else if (rst_after > 0 && idx == rst_after) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_ready", rdy, 0);
                chk("rst_mid_valid", vld, 0);
                chk("rst_mid_out", dout, 0);
                chk("rst_mid_done", dn, 0);
                @(negedge clk);
                rst = 1'b0;
                fin = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
                if (start_beat > 0 && beats.size() == start_beat && !started) begin
                    started = 1'b1;
                    if (use_b) start_b = 1'b1; else start_a = 1'b1;
                end
                if (idx == 2 && bub_cnt < bub_len && rdy) begin
                    feature_valid = 1'b0;
                    feature_in    = 16'hC000 + 16'(cyc);
                    bub_cnt++;
                end else begin
                    // Valid stays high even while not ready, carrying junk data.
                    feature_valid = 1'b1;
                    feature_in    = (rdy && idx < npix) ? 16'(idx + 1) : 16'hA000 + 16'(cyc);
                end
                if (feature_valid && rdy) begin
                    if (xfers == 0) first_xfer_cyc = cyc;
                    xfers++;
                    if (idx < npix) idx++;
                end
                @(negedge clk);
            end
        end
        feature_valid = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        timed_out = !fin;
    endtask

    task automatic apply_vec(input vec_t v);
        bit to;
        int bad, last;
        run_frame(v.use_b, v.npix, v.bub, v.start_beat, 0, to);
        chk({v.name, "_timeout"}, to, 0);
        chk({v.name, "_beats"}, beats.size(), v.exp_beats);
        bad = 0;
        for (int k = 0; k < beats.size(); k++)
            if (beats[k] != exp_beat(k)) bad++;
        chk({v.name, "_stream_bad"}, bad, 0);
        if (beats.size() == v.exp_beats) begin
            chk({v.name, "_spot0"}, beats[v.s0i], v.s0v);
            chk({v.name, "_spot1"}, beats[v.s1i], v.s1v);
            chk({v.name, "_spot2"}, beats[v.s2i], v.s2v);
            chk({v.name, "_repeat_contig"}, beat_cyc[15] - beat_cyc[8], 7);
            if (v.bub == 0)
                chk({v.name, "_all_contig"}, beat_cyc[v.exp_beats-1] - beat_cyc[0], v.exp_beats - 1);
            else
                chk({v.name, "_has_gap"}, (beat_cyc[v.exp_beats-1] - beat_cyc[0]) > (v.exp_beats - 1), 1);
            last = beat_cyc[v.exp_beats-1];
            chk({v.name, "_latency"}, beat_cyc[0], first_xfer_cyc + 1);
        end else begin
            last = -99;
        end
        chk({v.name, "_transfers"}, xfers, v.npix);
        chk({v.name, "_done_cnt"}, done_cnt, 1);
        chk({v.name, "_done_cycle"}, done_cyc, last + 1);
        chk({v.name, "_done_vld_low"}, done_vld, 0);
        chk({v.name, "_idle_ready"}, idle_rdy, 0);
    endtask

    initial begin
        bit to;
        vecs[0] = '{"basic",  1'b0, 8,  0, 0,  32, 8,  1, 16, 5,  31, 8};
        vecs[1] = '{"bubble", 1'b0, 8,  3, 0,  32, 4,  3, 12, 3,  28, 7};
        vecs[2] = '{"busy",   1'b0, 8,  0, 10, 32, 0,  1, 10, 2,  20, 7};
        vecs[3] = '{"multi",  1'b1, 16, 0, 0,  64, 32, 9, 48, 13, 63, 16};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        feature_valid = 1'b0; feature_in = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready_a", ready_a, 0);
        chk("reset_valid_a", vld_a, 0);
        chk("reset_out_a", out_a, 0);
        chk("reset_done_a", done_a, 0);
        chk("reset_ready_b", ready_b, 0);
        chk("reset_valid_b", vld_b, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_a", ready_a, 0);

        for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

        // Reset after pixel 2, then a fresh frame must match the basic one.
        run_frame(1'b0, 8, 0, 0, 2, to);
        chk("rst_seq_timeout", to, 0);
        apply_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
